// File: rtl/onehot_range_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onehot_range_pkg
// Brief    : Shared FSM state type and default width for onehot_range_fill.
// Revision : 1.0 - initial release
// ============================================================================
package onehot_range_pkg;

  localparam int c_DEFAULT_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : onehot_range_pkg
`default_nettype wire

// File: rtl/onehot_enc.sv
`default_nettype none
// ============================================================================
// Module   : onehot_enc
// Brief    : One-hot to index encoder that also flags empty and multi-hot input.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_enc #(
  parameter int WIDTH = 12,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_zero,
  output logic             o_multi
);

  logic w_seen;

  // OR-ing indices is exact for one-hot input; multi-hot is flagged separately.
  always_comb begin
    o_idx   = '0;
    o_multi = 1'b0;
    w_seen  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) begin
        o_idx = o_idx | IDX_W'(i);
        if (w_seen) o_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
    o_zero = !w_seen;
  end

endmodule : onehot_enc
`default_nettype wire

// File: rtl/onehot_range_fill.sv
`default_nettype none
// ============================================================================
// Module   : onehot_range_fill
// Brief    : Rebuilds a contiguous bit mask from its left/right one-hot edge
//            markers, filling one bit per cycle, with malformed-pair detection.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_range_fill
  import onehot_range_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] left_i,
  input  logic [WIDTH-1:0] right_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] mask_o,
  output logic             err_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_left;
  logic [WIDTH-1:0]   r_right;
  logic [WIDTH-1:0]   r_mask;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_err;

  logic [c_CNT_W-1:0] w_left_idx;
  logic [c_CNT_W-1:0] w_right_idx;
  logic               w_left_zero;
  logic               w_right_zero;
  logic               w_left_multi;
  logic               w_right_multi;
  logic               w_accept;
  logic               w_both_zero;
  logic               w_illegal;
  logic               w_fill_last;

  onehot_enc #(.WIDTH(WIDTH), .IDX_W(c_CNT_W)) u_enc_left (
    .i_vec   (r_left),
    .o_idx   (w_left_idx),
    .o_zero  (w_left_zero),
    .o_multi (w_left_multi)
  );

  onehot_enc #(.WIDTH(WIDTH), .IDX_W(c_CNT_W)) u_enc_right (
    .i_vec   (r_right),
    .o_idx   (w_right_idx),
    .o_zero  (w_right_zero),
    .o_multi (w_right_multi)
  );

  assign w_accept    = valid_i && ready_o;
  assign w_both_zero = w_left_zero && w_right_zero;
  assign w_illegal   = w_left_multi || w_right_multi ||
                       (w_left_zero != w_right_zero) ||
                       (!w_both_zero && (w_left_idx < w_right_idx));
  assign w_fill_last = (r_cnt == w_left_idx);

  always_ff @(posedge clk_i) begin
    if (srst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_CHECK;
      ST_CHECK: w_state_next = (w_illegal || w_both_zero) ? ST_DONE : ST_FILL;
      ST_FILL:  if (w_fill_last) w_state_next = ST_DONE;
      ST_DONE:  if (ready_i) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Counter stops at the left index, so it never runs past WIDTH-1.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_left  <= '0;
      r_right <= '0;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_left  <= left_i;
            r_right <= right_i;
          end
        end
        ST_CHECK: begin
          r_mask <= '0;
          r_cnt  <= w_right_idx;
          r_err  <= w_illegal;
        end
        ST_FILL: begin
          r_mask[r_cnt] <= 1'b1;
          if (!w_fill_last) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_o = (r_state == ST_DONE);
    ready_o = (r_state == ST_IDLE) && !srst_i;
    mask_o  = valid_o ? r_mask : '0;
    err_o   = valid_o && r_err;
  end

endmodule : onehot_range_fill
`default_nettype wire
